// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register, field and immediate decode, and early JAL redirect.
// A wrong-path instruction behind every JAL is squashed into a bubble on the next non-stall edge.
module decode_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] instruction,
  input  logic        stall,
  input  logic        flush,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [6:0]  id_opcode,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2,
  output logic [2:0]  id_funct3,
  output logic [6:0]  id_funct7,
  output logic [31:0] id_imm,
  output logic        id_illegal,
  output logic        jump,
  output logic [31:0] jump_tgt
);

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_FENCE = 7'b0001111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  logic squash_pending;

  function automatic logic [31:0] imm_of(input logic [31:0] ins);
    logic [31:0] imm;
    imm = 32'h0;
    case (ins[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYS, OP_FENCE:
        imm = {{20{ins[31]}}, ins[31:20]};
      OP_STORE:
        imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OP_BR:
        imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {ins[31:12], 12'h000};
      OP_JAL:
        imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default:
        imm = 32'h0;
    endcase
    return imm;
  endfunction

  // Every supported opcode already ends in 2'b11, so this also rejects compressed encodings.
  function automatic logic illegal_of(input logic [31:0] ins);
    logic ill;
    case (ins[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYS, OP_FENCE, OP_STORE,
      OP_BR, OP_LUI, OP_AUIPC, OP_JAL, OP_REG: ill = 1'b0;
      default:                                 ill = 1'b1;
    endcase
    return ill;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid       <= 1'b0;
      id_pc          <= 32'h0;
      id_instr       <= NOP_INSTR;
      id_imm         <= imm_of(NOP_INSTR);
      id_illegal     <= illegal_of(NOP_INSTR);
      jump           <= 1'b0;
      jump_tgt       <= 32'h0;
      squash_pending <= 1'b0;
    end else if (flush || (squash_pending && !stall)) begin
      id_valid       <= 1'b0;
      id_pc          <= pc;
      id_instr       <= NOP_INSTR;
      id_imm         <= imm_of(NOP_INSTR);
      id_illegal     <= illegal_of(NOP_INSTR);
      jump           <= 1'b0;
      squash_pending <= 1'b0;
    end else if (stall) begin
      jump <= 1'b0;
    end else begin
      id_valid   <= 1'b1;
      id_pc      <= pc;
      id_instr   <= instruction;
      id_imm     <= imm_of(instruction);
      id_illegal <= illegal_of(instruction);
      if (instruction[6:0] == OP_JAL) begin
        jump           <= 1'b1;
        jump_tgt       <= pc + imm_of(instruction);
        squash_pending <= 1'b1;
      end else begin
        jump <= 1'b0;
      end
    end
  end

  assign id_opcode = id_instr[6:0];
  assign id_rd     = id_instr[11:7];
  assign id_funct3 = id_instr[14:12];
  assign id_rs1    = id_instr[19:15];
  assign id_rs2    = id_instr[24:20];
  assign id_funct7 = id_instr[31:25];

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a table of single-capture vectors plus
// hand-written JAL/stall/flush/reset sequences, checked through an expectation queue.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [31:0] pc, instruction;
  logic        id_valid, id_illegal, jump;
  logic [31:0] id_pc, id_instr, id_imm, jump_tgt;
  logic [6:0]  id_opcode, id_funct7;
  logic [4:0]  id_rd, id_rs1, id_rs2;
  logic [2:0]  id_funct3;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] JAL8 = 32'h008000EF;
  localparam logic [31:0] ADDI = 32'h00500093;

  decode_stage dut (
    .clk(clk), .reset(reset), .pc(pc), .instruction(instruction),
    .stall(stall), .flush(flush), .id_valid(id_valid), .id_pc(id_pc),
    .id_instr(id_instr), .id_opcode(id_opcode), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_funct3(id_funct3),
    .id_funct7(id_funct7), .id_imm(id_imm), .id_illegal(id_illegal),
    .jump(jump), .jump_tgt(jump_tgt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] imm;
    logic        illegal;
    logic        jump;
    logic [31:0] tgt;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] imm;
    logic        illegal;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(input logic v, input logic [31:0] p, input logic [31:0] i,
                              input logic [31:0] imm, input logic ill, input logic j,
                              input logic [31:0] t);
    exp_t e;
    e.valid = v; e.pc = p; e.instr = i; e.imm = imm; e.illegal = ill; e.jump = j; e.tgt = t;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
    end
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, ".valid"},   {31'b0, id_valid},   {31'b0, e.valid});
    chk({tag, ".pc"},      id_pc,               e.pc);
    chk({tag, ".instr"},   id_instr,            e.instr);
    chk({tag, ".opcode"},  {25'b0, id_opcode},  {25'b0, e.instr[6:0]});
    chk({tag, ".rd"},      {27'b0, id_rd},      {27'b0, e.instr[11:7]});
    chk({tag, ".funct3"},  {29'b0, id_funct3},  {29'b0, e.instr[14:12]});
    chk({tag, ".rs1"},     {27'b0, id_rs1},     {27'b0, e.instr[19:15]});
    chk({tag, ".rs2"},     {27'b0, id_rs2},     {27'b0, e.instr[24:20]});
    chk({tag, ".funct7"},  {25'b0, id_funct7},  {25'b0, e.instr[31:25]});
    chk({tag, ".imm"},     id_imm,              e.imm);
    chk({tag, ".illegal"}, {31'b0, id_illegal}, {31'b0, e.illegal});
    chk({tag, ".jump"},    {31'b0, jump},       {31'b0, e.jump});
    chk({tag, ".tgt"},     jump_tgt,            e.tgt);
  endtask

  // Drive one edge's inputs, queue what the registers must hold after that edge, then check.
  task automatic step(input string tag, input logic r, input logic s, input logic f,
                      input logic [31:0] p, input logic [31:0] i, input exp_t e);
    reset = r; stall = s; flush = f; pc = p; instruction = i;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{32'h00000000, 32'h00500093, 32'h00000005, 1'b0}; // addi x1,x0,5
    vecs[1]  = '{32'h00000004, 32'hFE000EE3, 32'hFFFFFFFC, 1'b0}; // beq x0,x0,-4
    vecs[2]  = '{32'h00000008, 32'h0020A623, 32'h0000000C, 1'b0}; // sw x2,12(x1)
    vecs[3]  = '{32'h0000000C, 32'h123452B7, 32'h12345000, 1'b0}; // lui x5
    vecs[4]  = '{32'h00000010, 32'h0000007F, 32'h00000000, 1'b1}; // opcode 0x7F
    vecs[5]  = '{32'h00000014, 32'h00A00090, 32'h00000000, 1'b1}; // instr[1:0]=00
    vecs[6]  = '{32'h00000018, 32'h002081B3, 32'h00000000, 1'b0}; // add x3,x1,x2
    vecs[7]  = '{32'h0000001C, 32'hFFFFF297, 32'hFFFFF000, 1'b0}; // auipc x5
    vecs[8]  = '{32'h00000020, 32'hFF812303, 32'hFFFFFFF8, 1'b0}; // lw x6,-8(x2)
    vecs[9]  = '{32'h00000024, 32'h00008067, 32'h00000000, 1'b0}; // jalr x0,0(x1)
    vecs[10] = '{32'h00000028, 32'hFE112FA3, 32'hFFFFFFFF, 1'b0}; // sw imm -1
    vecs[11] = '{32'h0000002C, 32'h0FF0000F, 32'h000000FF, 1'b0}; // fence

    reset = 1'b1; stall = 1'b0; flush = 1'b0; pc = 32'h0; instruction = 32'h0;
    @(posedge clk);
    #1;
    step("reset", 1'b1, 1'b0, 1'b0, 32'h1234, ADDI, mk(0, 32'h0, NOP, 32'h0, 0, 0, 32'h0));

    foreach (vecs[k])
      step($sformatf("vec%0d", k), 1'b0, 1'b0, 1'b0, vecs[k].pc, vecs[k].instr,
           mk(1, vecs[k].pc, vecs[k].instr, vecs[k].imm, vecs[k].illegal, 0, 32'h0));

    // JAL, wrong-path squash, then normal capture
    step("jal",     0, 0, 0, 32'h10, JAL8, mk(1, 32'h10, JAL8, 32'h8, 0, 1, 32'h18));
    step("squash",  0, 0, 0, 32'h14, ADDI, mk(0, 32'h14, NOP, 32'h0, 0, 0, 32'h18));
    step("post_j",  0, 0, 0, 32'h18, ADDI, mk(1, 32'h18, ADDI, 32'h5, 0, 0, 32'h18));

    // stall holds, flush overrides stall
    step("cap",     0, 0, 0, 32'h20, ADDI, mk(1, 32'h20, ADDI, 32'h5, 0, 0, 32'h18));
    for (int n = 0; n < 3; n++)
      step($sformatf("stall%0d", n), 0, 1, 0, 32'h24 + 32'(4 * n), 32'h002081B3 + 32'(n),
           mk(1, 32'h20, ADDI, 32'h5, 0, 0, 32'h18));
    step("flush_st", 0, 1, 1, 32'h30, ADDI, mk(0, 32'h30, NOP, 32'h0, 0, 0, 32'h18));

    // JAL held by stall: pulse lasts one cycle, squash waits for the first non-stall edge
    step("jal2",    0, 0, 0, 32'h40, JAL8, mk(1, 32'h40, JAL8, 32'h8, 0, 1, 32'h48));
    step("j2st0",   0, 1, 0, 32'h44, ADDI, mk(1, 32'h40, JAL8, 32'h8, 0, 0, 32'h48));
    step("j2st1",   0, 1, 0, 32'h44, ADDI, mk(1, 32'h40, JAL8, 32'h8, 0, 0, 32'h48));
    step("j2sq",    0, 0, 0, 32'h48, ADDI, mk(0, 32'h48, NOP, 32'h0, 0, 0, 32'h48));
    step("j2cap",   0, 0, 0, 32'h48, ADDI, mk(1, 32'h48, ADDI, 32'h5, 0, 0, 32'h48));

    // reset mid-stall clears the pending squash
    step("jal3",    0, 0, 0, 32'h50, JAL8, mk(1, 32'h50, JAL8, 32'h8, 0, 1, 32'h58));
    step("j3st",    0, 1, 0, 32'h54, ADDI, mk(1, 32'h50, JAL8, 32'h8, 0, 0, 32'h58));
    step("j3rst",   1, 1, 0, 32'h54, ADDI, mk(0, 32'h0, NOP, 32'h0, 0, 0, 32'h0));
    step("j3cap",   0, 0, 0, 32'h58, ADDI, mk(1, 32'h58, ADDI, 32'h5, 0, 0, 32'h0));

    // target wraps; a flush while the squash is pending absorbs it
    step("wrap",    0, 0, 0, 32'hFFFFFFFC, JAL8, mk(1, 32'hFFFFFFFC, JAL8, 32'h8, 0, 1, 32'h4));
    step("wr_fl",   0, 0, 1, 32'h00000000, ADDI, mk(0, 32'h0, NOP, 32'h0, 0, 0, 32'h4));
    step("wr_cap",  0, 0, 0, 32'h00000004, ADDI, mk(1, 32'h4, ADDI, 32'h5, 0, 0, 32'h4));

    // flush on a JAL capture edge: no jump, no squash afterwards
    step("fl_jal",  0, 0, 1, 32'h60, JAL8, mk(0, 32'h60, NOP, 32'h0, 0, 0, 32'h4));
    step("fl_cap",  0, 0, 0, 32'h64, ADDI, mk(1, 32'h64, ADDI, 32'h5, 0, 0, 32'h4));

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage of the RV32I core. Sits directly downstream of the fetch/PC block: it registers each `pc`/`instruction` pair from fetch into the IF/ID register and decodes RV32I fields and immediates for execute. It resolves JAL early, driving the fetch block's `jump`/`jump_tgt` inputs and squashing the wrong-path instruction behind it. Supports stall and flush from the hazard/branch logic.

## Interface
Parameters:
- `NOP_INSTR`, default 32'h00000013 (addi x0,x0,0), the bubble encoding loaded on flush, squash and reset.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high reset.
- `pc` input 32: PC of the instruction currently presented by fetch.
- `instruction` input 32: instruction word at `pc`.
- `stall` input 1: hold the IF/ID contents this edge.
- `flush` input 1: load a bubble this edge; used on taken branch. Overrides `stall`.
- `id_valid` output 1: the IF/ID register holds a real instruction.
- `id_pc` output 32: registered PC.
- `id_instr` output 32: registered instruction.
- `id_opcode` output 7: `id_instr[6:0]`.
- `id_rd`, `id_rs1`, `id_rs2` output 5 each: `[11:7]`, `[19:15]`, `[24:20]`.
- `id_funct3` output 3 / `id_funct7` output 7: `[14:12]` / `[31:25]`.
- `id_imm` output 32: sign-extended immediate.
- `id_illegal` output 1: unsupported opcode, or `instr[1:0]` != 2'b11.
- `jump` output 1: single-cycle request to fetch to redirect.
- `jump_tgt` output 32: redirect target (`id_pc` + J-immediate).

## Operation
- All outputs are registered and update only on the rising edge of `clk`.
- Edge priority, highest first: `reset` > `flush` > squash > `stall` > capture.
  - Reset: `id_valid`=0, `id_pc`=0, `id_instr`=`NOP_INSTR`, decoded fields decode the NOP, `id_illegal`=0, `jump`=0, `jump_tgt`=0, `squash_pending`=0.
  - Flush: load bubble (`id_valid`=0, `id_instr`=`NOP_INSTR`, `id_pc`=`pc`); `jump`=0; `squash_pending`=0.
  - Squash: applies when `squash_pending`=1 and `stall`=0. Load bubble, `jump`=0, clear `squash_pending`.
  - Stall (no flush): hold all IF/ID registers; `jump`=0.
  - Capture: `id_pc`=`pc`, `id_instr`=`instruction`, `id_valid`=1, fields and immediate decoded from `instruction`.
- Immediate by opcode:
  - I-type: 0010011, 0000011, 1100111, 1110011, 0001111 → sext(`[31:20]`).
  - S-type: 0100011 → sext({`[31:25]`,`[11:7]`}).
  - B-type: 1100011 → sext({`[31]`,`[7]`,`[30:25]`,`[11:8]`,0}).
  - U-type: 0110111, 0010111 → {`[31:12]`, 12'b0}.
  - J-type: 1101111 → sext({`[31]`,`[19:12]`,`[20]`,`[30:21]`,0}).
  - R-type: 0110011 → imm = 0.
  - Any other opcode: imm = 0, `id_illegal`=1 (`id_valid` still 1).
- JAL early resolution: on a capture edge with opcode 1101111 and `instr[1:0]`=11, set `jump`=1 and `jump_tgt`=`pc`+J-imm (mod 2^32), and set `squash_pending`=1.
- JALR and branches are not resolved here; they pass through with their immediate.
- `jump` is a pulse: forced to 0 on every edge that is not a JAL capture.

## Timing
- Latency: one cycle from fetch presenting `pc`/`instruction` to the `id_*` outputs.
- `jump` is asserted in the cycle after JAL capture. Fetch redirects on the following edge.
- The instruction fetch presents while `jump`=1 (JAL pc+4) is wrong-path. It is dropped by the squash on the next non-stall edge, giving one bubble after every JAL.
- If `stall`=1 while `squash_pending`=1, the squash waits for the first non-stall edge.
- Flush during `squash_pending` clears it: the flush bubble already covers the wrong path.
- Simultaneous `flush` and JAL capture: flush wins, no `jump`.
- Reset mid-operation: all state returns to reset values on that edge. The first capture is on the first edge with `reset`=0.
- JAL target arithmetic wraps modulo 2^32, e.g. pc 0xFFFFFFFC + 8 → 0x00000004.

## Test plan
- Reset, then `pc`=0x0, `instruction`=0x00500093 → next cycle `id_valid`=1, `id_rd`=1, `id_rs1`=0, `id_imm`=0x00000005, `jump`=0.
- `pc`=0x10, `instruction`=0x008000EF (jal x1,8) → `jump`=1 for exactly one cycle, `jump_tgt`=0x18, `id_rd`=1. Following capture (pc 0x14) yields `id_valid`=0, `id_instr`=0x00000013.
- 0xFE000EE3 (beq x0,x0,-4) → `id_imm`=0xFFFFFFFC, `jump`=0. 0x0020A623 (sw x2,12(x1)) → `id_imm`=12, `id_rs1`=1, `id_rs2`=2.
- 0x123452B7 (lui x5) → `id_imm`=0x12345000, `id_rd`=5. Opcode 0x7F or `instr[1:0]`=00 → `id_illegal`=1.
- Capture addi, then hold `stall`=1 for 3 cycles while changing `instruction` → all `id_*` unchanged. Assert `flush`=1 with `stall`=1 → bubble on that edge.
- JAL capture followed by `stall`=1 for 2 cycles → `jump` high 1 cycle only, squash on the first non-stall edge. Repeat with `reset`=1 asserted mid-stall → all outputs at reset values next cycle, no squash afterwards.
